// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared opcodes, sequencer state encoding and size defaults for
//            the calculator register-file sequencer.
// Revision : 1.0
// ============================================================================
package calc_pkg;

    localparam int CALC_WIDTH = 16;
    localparam int CALC_SELW  = 2;

    localparam logic [2:0] OP_LDI = 3'b000;
    localparam logic [2:0] OP_MOV = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RDA  = 2'd1,
        S_RDB  = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rf_alu.sv
`default_nettype none
// ============================================================================
// Module   : rf_alu
// Purpose  : Combinational result/carry generator for one calculator command.
// Revision : 1.0
// ============================================================================
module rf_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    input  logic [WIDTH-1:0] i_imm,
    output logic [WIDTH-1:0] o_value,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_opa} + {1'b0, i_opb};

    always_comb begin
        o_value = '0;
        o_carry = 1'b0;
        case (i_op)
            OP_LDI: o_value = i_imm;
            OP_MOV: o_value = i_opa;
            OP_ADD: begin
                o_value = w_sum[WIDTH-1:0];
                o_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                o_value = i_opa - i_opb;
                o_carry = (i_opa < i_opb);
            end
            OP_AND: o_value = i_opa & i_opb;
            OP_OR:  o_value = i_opa | i_opb;
            OP_XOR: o_value = i_opa ^ i_opb;
            default: o_value = ~i_opa;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/regfile_seq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_seq
// Purpose  : Sequences one calculator command at a time through regfile1's
//            single read port and write port.
// Revision : 1.0
// ============================================================================
module regfile_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH,
    parameter int SELW  = CALC_SELW
) (
    input  logic             ck,
    input  logic             res,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [SELW-1:0]  cmd_ra,
    input  logic [SELW-1:0]  cmd_rb,
    input  logic [SELW-1:0]  cmd_rd,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic [SELW-1:0]  rf_rsel,
    input  logic [WIDTH-1:0] rf_q,
    output logic [SELW-1:0]  rf_wsel,
    output logic [WIDTH-1:0] rf_d,
    output logic             rf_we
);

    state_t           r_state;
    logic [2:0]       r_op;
    logic [SELW-1:0]  r_ra;
    logic [SELW-1:0]  r_rb;
    logic [SELW-1:0]  r_rd;
    logic [SELW-1:0]  r_wsel;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic             r_z;
    logic             r_c;

    logic [WIDTH-1:0] w_alu;
    logic             w_carry;
    logic             w_in_wb;
    logic             w_sets_c;

    rf_alu #(.WIDTH(WIDTH)) u_alu (
        .i_op    (r_op),
        .i_opa   (r_opa),
        .i_opb   (r_opb),
        .i_imm   (r_imm),
        .o_value (w_alu),
        .o_carry (w_carry)
    );

    assign w_in_wb  = (r_state == S_WB);
    assign w_sets_c = (r_op == OP_ADD) || (r_op == OP_SUB);

    always_ff @(posedge ck) begin
        if (res) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_rd     <= '0;
            r_wsel   <= '0;
            r_imm    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_ra    <= cmd_ra;
                        r_rb    <= cmd_rb;
                        r_rd    <= cmd_rd;
                        r_imm   <= cmd_imm;
                        r_state <= (cmd_op == OP_LDI) ? S_WB : S_RDA;
                    end
                end
                S_RDA: begin
                    r_opa   <= rf_q;
                    r_state <= (r_op == OP_MOV || r_op == OP_NOT) ? S_WB : S_RDB;
                end
                S_RDB: begin
                    r_opb   <= rf_q;
                    r_state <= S_WB;
                end
                default: begin
                    r_result <= w_alu;
                    r_z      <= (w_alu == '0);
                    if (w_sets_c) begin
                        r_c <= w_carry;
                    end
                    r_wsel  <= r_rd;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outside WB the write-port fields replay the last write so regfile1 sees stable values.
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = w_in_wb & ~res;
    assign rf_we     = w_in_wb & ~res;
    assign rf_wsel   = w_in_wb ? r_rd : r_wsel;
    assign rf_d      = w_in_wb ? w_alu : r_result;
    assign rf_rsel   = (r_state == S_RDA) ? r_ra :
                       (r_state == S_RDB) ? r_rb : '0;
    assign result    = r_result;
    assign flag_z    = r_z;
    assign flag_c    = r_c;

endmodule
`default_nettype wire
